uart_cfg_regbank: RTL and testbench

//  Multi-channel UART configuration register bank; successor of the single-channel control core.
//  - Host writes go to per-channel shadow registers.
//  - A commit command copies shadow to the active outputs, but only once that channel's

---
 rtl/uart_cfg_regbank.sv | 180 ++++++++++++++++++
 tb/tb_uart_cfg_regbank.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_regbank.sv
`default_nettype none
// ============================================================================
// Module  : uart_cfg_regbank
// Brief   : Per-channel UART config shadow registers with idle-gated commit.
// Revision: 1.0
// ============================================================================
module uart_cfg_regbank #(
   parameter int          CH_W           = 1,
   parameter logic [11:0] DEFAULT_PERIOD = 12'd20,
   parameter logic [3:0]  DEFAULT_UP     = 4'd10,
   parameter logic [3:0]  DEFAULT_DOWN   = 4'd5,
   parameter logic [11:0] MIN_PERIOD     = 12'd8,
   localparam int         NUM_CH         = 2**CH_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   p_We_i,
   input  logic                   p_Re_i,
   input  logic [CH_W+1:0]        Addr_i,
   input  logic [7:0]             WrData_i,
   output logic [7:0]             RdData_o,
   input  logic [NUM_CH-1:0]      p_Busy_i,
   output logic [NUM_CH*12-1:0]   AcqPeriod_o,
   output logic [NUM_CH*8-1:0]    BitCompensation_o,
   output logic [NUM_CH-1:0]      p_ParityEnable_o,
   output logic [NUM_CH-1:0]      p_BigEnd_o,
   output logic [NUM_CH-1:0]      ParityMethod_o,
   output logic [NUM_CH-1:0]      p_CfgDone_o,
   output logic [NUM_CH-1:0]      p_CfgErr_o
);

   typedef struct packed {
      logic        big;
      logic        pen;
      logic        meth;
      logic [11:0] period;
      logic [7:0]  comp;
   } cfg_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

   localparam cfg_t CFG_RST = cfg_t'({1'b0, 1'b1, 1'b1, DEFAULT_PERIOD, DEFAULT_UP, DEFAULT_DOWN});

   cfg_t              shadow_q [NUM_CH];
   cfg_t              shadow_d [NUM_CH];
   cfg_t              active_q [NUM_CH];
   cfg_t              active_d [NUM_CH];
   state_t            state_q  [NUM_CH];
   state_t            state_d  [NUM_CH];
   logic [NUM_CH-1:0] err_q, err_d;
   logic [NUM_CH-1:0] done_q, done_d;
   logic [7:0]        rd_data_q, rd_data_d;

   logic [CH_W-1:0]   addr_ch;
   logic [1:0]        addr_reg;

   assign addr_ch  = Addr_i[CH_W+1:2];
   assign addr_reg = Addr_i[1:0];

   // Compensation sum is widened to 12 bits so it can never wrap.
   function automatic logic cfg_valid(input cfg_t c);
      logic [11:0] comp_sum;
      comp_sum = 12'(c.comp[7:4]) + 12'(c.comp[3:0]);
      return (c.period >= MIN_PERIOD) && (comp_sum < c.period);
   endfunction

   always_comb begin
      err_d  = err_q;
      done_d = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         shadow_d[ch] = shadow_q[ch];
         active_d[ch] = active_q[ch];
         state_d[ch]  = state_q[ch];
      end

      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (p_We_i && (addr_ch == CH_W'(ch))) begin
            case (addr_reg)
               2'd0: begin
                  shadow_d[ch].big           = WrData_i[7];
                  shadow_d[ch].pen           = WrData_i[6];
                  shadow_d[ch].meth          = WrData_i[5];
                  shadow_d[ch].period[11:8]  = WrData_i[3:0];
               end
               2'd1: shadow_d[ch].period[7:0] = WrData_i;
               2'd2: shadow_d[ch].comp        = WrData_i;
               default: begin
                  if (WrData_i[1]) begin
                     err_d[ch] = 1'b0;
                  end
                  if (WrData_i[0] && (state_q[ch] == ST_IDLE)) begin
                     state_d[ch] = ST_WAIT;
                  end
               end
            endcase
         end

         // Applies the pre-write shadow; an error set here overrides a same-cycle clear.
         case (state_q[ch])
            ST_WAIT: begin
               if (!p_Busy_i[ch]) begin
                  state_d[ch] = ST_APPLY;
               end
            end
            ST_APPLY: begin
               state_d[ch] = ST_IDLE;
               if (cfg_valid(shadow_q[ch])) begin
                  active_d[ch] = shadow_q[ch];
                  done_d[ch]   = 1'b1;
               end else begin
                  err_d[ch] = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (p_Re_i) begin
         case (addr_reg)
            2'd0: rd_data_d = {shadow_q[addr_ch].big, shadow_q[addr_ch].pen,
                               shadow_q[addr_ch].meth, 1'b0,
                               shadow_q[addr_ch].period[11:8]};
            2'd1: rd_data_d = shadow_q[addr_ch].period[7:0];
            2'd2: rd_data_d = shadow_q[addr_ch].comp;
            default: rd_data_d = {5'b0, p_Busy_i[addr_ch], err_q[addr_ch],
                                  (state_q[addr_ch] != ST_IDLE)};
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            shadow_q[ch] <= CFG_RST;
            active_q[ch] <= CFG_RST;
            state_q[ch]  <= ST_IDLE;
         end
         err_q     <= '0;
         done_q    <= '0;
         rd_data_q <= '0;
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            shadow_q[ch] <= shadow_d[ch];
            active_q[ch] <= active_d[ch];
            state_q[ch]  <= state_d[ch];
         end
         err_q     <= err_d;
         done_q    <= done_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_comb begin
      AcqPeriod_o       = '0;
      BitCompensation_o = '0;
      p_ParityEnable_o  = '0;
      p_BigEnd_o        = '0;
      ParityMethod_o    = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         AcqPeriod_o[ch*12 +: 12]     = active_q[ch].period;
         BitCompensation_o[ch*8 +: 8] = active_q[ch].comp;
         p_ParityEnable_o[ch]         = active_q[ch].pen;
         p_BigEnd_o[ch]               = active_q[ch].big;
         ParityMethod_o[ch]           = active_q[ch].meth;
      end
   end

   assign RdData_o    = rd_data_q;
   assign p_CfgDone_o = done_q;
   assign p_CfgErr_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cfg_regbank.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_cfg_regbank
// Brief   : Vector table, directed corner sequences and random traffic vs model.
// Revision: 1.0
// ============================================================================
module tb_uart_cfg_regbank;

   localparam int NUM_CH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p_We_i = 1'b0;
   logic        p_Re_i = 1'b0;
   logic [2:0]  Addr_i = '0;
   logic [7:0]  WrData_i = '0;
   logic [7:0]  RdData_o;
   logic [1:0]  p_Busy_i = '0;
   logic [23:0] AcqPeriod_o;
   logic [15:0] BitCompensation_o;
   logic [1:0]  p_ParityEnable_o, p_BigEnd_o, ParityMethod_o, p_CfgDone_o, p_CfgErr_o;

   int n_vec = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   uart_cfg_regbank #(.CH_W(1)) dut (
      .clk               (clk),
      .rst               (rst),
      .p_We_i            (p_We_i),
      .p_Re_i            (p_Re_i),
      .Addr_i            (Addr_i),
      .WrData_i          (WrData_i),
      .RdData_o          (RdData_o),
      .p_Busy_i          (p_Busy_i),
      .AcqPeriod_o       (AcqPeriod_o),
      .BitCompensation_o (BitCompensation_o),
      .p_ParityEnable_o  (p_ParityEnable_o),
      .p_BigEnd_o        (p_BigEnd_o),
      .ParityMethod_o    (ParityMethod_o),
      .p_CfgDone_o       (p_CfgDone_o),
      .p_CfgErr_o        (p_CfgErr_o)
   );

   // ---------------- behavioural reference ----------------
   typedef struct {
      int per;
      int up;
      int dn;
      bit big;
      bit pen;
      bit meth;
   } cfg_m;

   cfg_m       sh  [NUM_CH];
   cfg_m       act [NUM_CH];
   bit         m_err  [NUM_CH];
   bit         m_pend [NUM_CH];   // commit accepted, not yet resolved
   bit         m_go   [NUM_CH];   // channel seen idle: resolves on next edge
   logic [7:0] m_rd;
   logic [1:0] m_done;

   function automatic bit cfg_ok(input cfg_m c);
      return (c.per >= 8) && ((c.up + c.dn) < c.per);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         sh[c]     = '{per: 20, up: 10, dn: 5, big: 1'b0, pen: 1'b1, meth: 1'b1};
         act[c]    = sh[c];
         m_err[c]  = 1'b0;
         m_pend[c] = 1'b0;
         m_go[c]   = 1'b0;
      end
      m_rd   = 8'h00;
      m_done = 2'b00;
   endtask

   function automatic logic [7:0] readback(input int c, input int r, input logic [1:0] busy);
      case (r)
         0:       return {sh[c].big, sh[c].pen, sh[c].meth, 1'b0, 4'(sh[c].per / 256)};
         1:       return 8'(sh[c].per % 256);
         2:       return 8'(sh[c].up * 16 + sh[c].dn);
         default: return {5'b0, busy[c], m_err[c], m_pend[c]};
      endcase
   endfunction

   task automatic model_step(input bit we, input bit re, input logic [2:0] addr,
                             input logic [7:0] wd, input logic [1:0] busy);
      int   ch;
      int   r;
      cfg_m old  [NUM_CH];
      bit   pend0[NUM_CH];
      bit   go0  [NUM_CH];
      ch = int'(addr[2]);
      r  = int'(addr[1:0]);
      old = sh;
      for (int c = 0; c < NUM_CH; c++) begin
         pend0[c] = m_pend[c];
         go0[c]   = m_go[c];
      end
      if (re) m_rd = readback(ch, r, busy);
      m_done = 2'b00;
      if (we) begin
         case (r)
            0: begin
               sh[ch].big  = wd[7];
               sh[ch].pen  = wd[6];
               sh[ch].meth = wd[5];
               sh[ch].per  = int'(wd[3:0]) * 256 + sh[ch].per % 256;
            end
            1: sh[ch].per = (sh[ch].per / 256) * 256 + int'(wd);
            2: begin
               sh[ch].up = int'(wd[7:4]);
               sh[ch].dn = int'(wd[3:0]);
            end
            default: begin
               if (wd[1]) m_err[ch] = 1'b0;
               if (wd[0] && !pend0[ch]) m_pend[ch] = 1'b1;
            end
         endcase
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (go0[c]) begin
            if (cfg_ok(old[c])) begin
               act[c]    = old[c];
               m_done[c] = 1'b1;
            end else begin
               m_err[c] = 1'b1;
            end
            m_go[c]   = 1'b0;
            m_pend[c] = 1'b0;
         end else if (pend0[c] && !busy[c]) begin
            m_go[c] = 1'b1;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [23:0] ep;
      logic [15:0] ec;
      logic [1:0]  epen, ebig, emeth, eerr;
      for (int c = 0; c < NUM_CH; c++) begin
         ep[c*12 +: 12] = 12'(act[c].per);
         ec[c*8 +: 8]   = 8'(act[c].up * 16 + act[c].dn);
         epen[c]        = act[c].pen;
         ebig[c]        = act[c].big;
         emeth[c]       = act[c].meth;
         eerr[c]        = m_err[c];
      end
      chk("rd_data",  32'(RdData_o),          32'(m_rd));
      chk("period",   32'(AcqPeriod_o),       32'(ep));
      chk("comp",     32'(BitCompensation_o), 32'(ec));
      chk("par_en",   32'(p_ParityEnable_o),  32'(epen));
      chk("big_end",  32'(p_BigEnd_o),        32'(ebig));
      chk("par_meth", 32'(ParityMethod_o),    32'(emeth));
      chk("done",     32'(p_CfgDone_o),       32'(m_done));
      chk("err",      32'(p_CfgErr_o),        32'(eerr));
   endtask

   task automatic cycle(input bit we, input bit re, input logic [2:0] addr,
                        input logic [7:0] wd, input logic [1:0] busy);
      p_We_i   = we;
      p_Re_i   = re;
      Addr_i   = addr;
      WrData_i = wd;
      p_Busy_i = busy;
      model_step(we, re, addr, wd, busy);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(input int n, input logic [1:0] busy);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 8'h00, busy);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit         we;
      bit         re;
      logic [2:0] addr;
      logic [7:0] wd;
      logic [1:0] busy;
      bit         chk_rd;
      logic [7:0] rd;
      bit         chk_done;
      logic [1:0] done;
      bit         chk_p1;
      logic [11:0] p1;
   } vec_t;

   vec_t tbl [14];

   initial begin
      bit seen;
      bit any_done;

      //          we  re  addr  wd     busy  crd rd     cdn done   cp1 p1
      tbl[0]  = '{0,  1,  3'd0, 8'h00, 2'b00, 1, 8'h60, 0, 2'b00, 0, 12'd0};
      tbl[1]  = '{0,  1,  3'd1, 8'h00, 2'b00, 1, 8'h14, 0, 2'b00, 0, 12'd0};
      tbl[2]  = '{0,  1,  3'd2, 8'h00, 2'b00, 1, 8'hA5, 0, 2'b00, 0, 12'd0};
      tbl[3]  = '{0,  1,  3'd3, 8'h00, 2'b00, 1, 8'h00, 0, 2'b00, 1, 12'd20};
      tbl[4]  = '{1,  0,  3'd4, 8'hA0, 2'b00, 0, 8'h00, 0, 2'b00, 1, 12'd20};
      tbl[5]  = '{1,  0,  3'd5, 8'h64, 2'b00, 0, 8'h00, 0, 2'b00, 0, 12'd0};
      tbl[6]  = '{1,  0,  3'd6, 8'h32, 2'b00, 0, 8'h00, 0, 2'b00, 0, 12'd0};
      tbl[7]  = '{1,  0,  3'd7, 8'h01, 2'b00, 0, 8'h00, 1, 2'b00, 1, 12'd20};
      tbl[8]  = '{0,  0,  3'd0, 8'h00, 2'b00, 0, 8'h00, 1, 2'b00, 1, 12'd20};
      tbl[9]  = '{0,  0,  3'd0, 8'h00, 2'b00, 0, 8'h00, 1, 2'b10, 1, 12'd100};
      tbl[10] = '{0,  0,  3'd0, 8'h00, 2'b00, 0, 8'h00, 1, 2'b00, 1, 12'd100};
      tbl[11] = '{0,  1,  3'd4, 8'h00, 2'b00, 1, 8'hA0, 0, 2'b00, 0, 12'd0};
      tbl[12] = '{0,  1,  3'd7, 8'h00, 2'b00, 1, 8'h00, 0, 2'b00, 0, 12'd0};
      tbl[13] = '{0,  1,  3'd0, 8'h00, 2'b00, 1, 8'h60, 0, 2'b00, 0, 12'd0};

      model_reset();
      #1 rst = 1'b0;
      #2 check_all();
      @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wd, tbl[i].busy);
         if (tbl[i].chk_rd)   chk($sformatf("tbl_rd[%0d]", i),   32'(RdData_o), 32'(tbl[i].rd));
         if (tbl[i].chk_done) chk($sformatf("tbl_done[%0d]", i), 32'(p_CfgDone_o), 32'(tbl[i].done));
         if (tbl[i].chk_p1)   chk($sformatf("tbl_p1[%0d]", i),   32'(AcqPeriod_o[23:12]), 32'(tbl[i].p1));
      end
      chk("ch1_comp", 32'(BitCompensation_o[15:8]), 32'h32);
      chk("ch0_period_kept", 32'(AcqPeriod_o[11:0]), 32'd20);

      // Commit held off by a busy engine, then released.
      cycle(1, 0, 3'd1, 8'h30, 2'b01);
      cycle(1, 0, 3'd3, 8'h01, 2'b01);
      idle(50, 2'b01);
      cycle(0, 1, 3'd3, 8'h00, 2'b01);
      chk("busy_cmd_rd", 32'(RdData_o), 32'h05);
      chk("busy_period_held", 32'(AcqPeriod_o[11:0]), 32'd20);
      seen = 1'b0;
      for (int i = 0; i < 2 && !seen; i++) begin
         idle(1, 2'b00);
         seen = p_CfgDone_o[0];
      end
      chk("release_done", 32'(seen), 32'd1);
      chk("release_period", 32'(AcqPeriod_o[11:0]), 32'd48);

      // Rejected commit (period below minimum), then error clear.
      cycle(1, 0, 3'd1, 8'h05, 2'b00);
      cycle(1, 0, 3'd0, 8'h60, 2'b00);
      cycle(1, 0, 3'd3, 8'h01, 2'b00);
      any_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idle(1, 2'b00);
         any_done |= p_CfgDone_o[0];
      end
      chk("reject_err", 32'(p_CfgErr_o[0]), 32'd1);
      chk("reject_nodone", 32'(any_done), 32'd0);
      chk("reject_period", 32'(AcqPeriod_o[11:0]), 32'd48);
      cycle(1, 0, 3'd3, 8'h02, 2'b00);
      chk("err_clear", 32'(p_CfgErr_o[0]), 32'd0);

      // Clear and commit in one write.
      cycle(1, 0, 3'd3, 8'h01, 2'b00);
      idle(3, 2'b00);
      cycle(1, 0, 3'd1, 8'h40, 2'b00);
      cycle(1, 0, 3'd3, 8'h03, 2'b00);
      chk("clr_commit_err", 32'(p_CfgErr_o[0]), 32'd0);
      idle(2, 2'b00);
      chk("clr_commit_period", 32'(AcqPeriod_o[11:0]), 32'd64);

      // Shadow write landing in the APPLY cycle.
      cycle(1, 0, 3'd1, 8'h50, 2'b00);
      cycle(1, 0, 3'd3, 8'h01, 2'b00);
      idle(1, 2'b00);
      cycle(1, 0, 3'd1, 8'h60, 2'b00);
      chk("apply_wr_period", 32'(AcqPeriod_o[11:0]), 32'd80);
      cycle(0, 1, 3'd1, 8'h00, 2'b00);
      chk("apply_wr_shadow", 32'(RdData_o), 32'h60);

      // Read and write to the same address in one cycle.
      cycle(1, 1, 3'd2, 8'h33, 2'b00);
      chk("rw_same_old", 32'(RdData_o), 32'hA5);
      cycle(0, 1, 3'd2, 8'h00, 2'b00);
      chk("rw_same_new", 32'(RdData_o), 32'h33);

      // Compensation sum boundary on ch1.
      cycle(1, 0, 3'd4, 8'h00, 2'b00);
      cycle(1, 0, 3'd5, 8'h10, 2'b00);
      cycle(1, 0, 3'd6, 8'h88, 2'b00);
      cycle(1, 0, 3'd7, 8'h01, 2'b00);
      idle(3, 2'b00);
      chk("bound_reject_err", 32'(p_CfgErr_o[1]), 32'd1);
      chk("bound_reject_period", 32'(AcqPeriod_o[23:12]), 32'd100);
      cycle(1, 0, 3'd7, 8'h02, 2'b00);
      cycle(1, 0, 3'd6, 8'h87, 2'b00);
      cycle(1, 0, 3'd7, 8'h01, 2'b00);
      idle(3, 2'b00);
      chk("bound_accept_period", 32'(AcqPeriod_o[23:12]), 32'd16);
      chk("bound_accept_err", 32'(p_CfgErr_o[1]), 32'd0);

      // Reset while a commit is waiting.
      cycle(1, 0, 3'd3, 8'h01, 2'b01);
      cycle(1, 0, 3'd1, 8'h99, 2'b01);
      rst = 1'b0;
      #2;
      model_reset();
      check_all();
      @(posedge clk);
      #1 rst = 1'b1;
      p_We_i = 1'b0;
      p_Re_i = 1'b0;
      cycle(0, 1, 3'd3, 8'h00, 2'b00);
      chk("rst_pending", 32'(RdData_o), 32'h00);
      any_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idle(1, 2'b00);
         any_done |= p_CfgDone_o[0];
      end
      chk("rst_nodone", 32'(any_done), 32'd0);
      chk("rst_period", 32'(AcqPeriod_o[11:0]), 32'd20);

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         bit         we;
         bit         re;
         logic [2:0] a;
         logic [7:0] d;
         logic [1:0] b;
         we = ($urandom_range(0, 2) == 0);
         re = ($urandom_range(0, 2) == 0);
         a  = 3'($urandom_range(0, 7));
         d  = 8'($urandom_range(0, 255));
         if (a[1:0] == 2'd3) d = 8'($urandom_range(0, 3));
         if (a[1:0] == 2'd1 && $urandom_range(0, 1) == 1) d = 8'($urandom_range(8, 40));
         b  = 2'($urandom_range(0, 3));
         cycle(we, re, a, d, b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
